// File: rtl/audio_pkg.sv
// Shared types and helpers for the multi-channel sample mixer.
package audio_pkg;

    localparam int unsigned GAIN_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StMix
    } mix_state_e;

    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 32'd1);
    endfunction

    // Clamp a signed value to the range of a width-bit two's complement number.
    function automatic int sat_signed(input int value, input int unsigned width);
        int hi;
        int lo;
        hi = int'(midscale(width)) - 1;
        lo = -int'(midscale(width));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/audio_dsm.sv
// First-order delta-sigma modulator: the carry out of a SAMPLE_W-bit phase accumulator.
module audio_dsm #(
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SAMPLE_W-1:0] pcm_i,
    output logic                audio_o
);

    logic [SAMPLE_W:0] acc_q;
    logic [SAMPLE_W:0] acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, pcm_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign audio_o = acc_q[SAMPLE_W];

endmodule

// File: rtl/audio_sample_mixer.sv
// Multi-voice sample player: one time-multiplexed ROM port, saturating mix,
// parallel PCM output and a delta-sigma audio pin.
module audio_sample_mixer
    import audio_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned DIV_W    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [DIV_W-1:0]             sample_div_i,
    input  logic [CHANNELS-1:0]          trig_i,
    input  logic [CHANNELS-1:0]          loop_i,
    input  logic [CHANNELS*ADDR_W-1:0]   start_addr_i,
    input  logic [CHANNELS*ADDR_W-1:0]   end_addr_i,
    input  logic [CHANNELS*GAIN_W-1:0]   gain_i,
    output logic                         rom_rd_o,
    output logic [ADDR_W-1:0]            rom_addr_o,
    input  logic [SAMPLE_W-1:0]          rom_data_i,
    output logic [CHANNELS-1:0]          busy_o,
    output logic [CHANNELS-1:0]          done_o,
    output logic [SAMPLE_W-1:0]          pcm_out_o,
    output logic                         pcm_valid_o,
    output logic                         audio_out_o,
    output logic                         overrun_o
);

    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned ACC_W = SAMPLE_W + $clog2(CHANNELS) + 1;
    localparam int unsigned EXT_W = ACC_W - SAMPLE_W;
    localparam logic [SAMPLE_W-1:0] MID     = SAMPLE_W'(midscale(SAMPLE_W));
    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(CHANNELS - 1);

    mix_state_e               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [CHANNELS-1:0]      pend_q, pend_d;
    logic [CHANNELS-1:0]      busy_q, busy_d;
    logic [CHANNELS-1:0]      done_q, done_d;
    logic [ADDR_W-1:0]        cur_q [CHANNELS];
    logic [ADDR_W-1:0]        cur_d [CHANNELS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [SAMPLE_W-1:0]      pcm_q, pcm_d;
    logic                     pcm_valid_q, pcm_valid_d;
    logic                     overrun_q, overrun_d;

    logic                       tick;
    logic [GAIN_W-1:0]          ch_gain;
    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [SAMPLE_W-1:0] shifted;
    logic signed [ACC_W-1:0]    contrib;
    int                         sat_val;

    assign tick = enable_i && (div_q == sample_div_i);

    // Offset-binary to two's complement is a flip of the MSB.
    assign ch_gain  = gain_i[ch_q*GAIN_W +: GAIN_W];
    assign sample_s = $signed(rom_data_i ^ MID);
    assign shifted  = sample_s >>> ch_gain;
    assign contrib  = {{EXT_W{shifted[SAMPLE_W-1]}}, shifted};
    assign sat_val  = sat_signed(int'(acc_q), SAMPLE_W);

    assign rom_rd_o   = (state_q == StAddr) && busy_q[ch_q];
    assign rom_addr_o = rom_rd_o ? cur_q[ch_q] : '0;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        div_d       = '0;
        pend_d      = pend_q | trig_i;
        busy_d      = busy_q;
        done_d      = '0;
        cur_d       = cur_q;
        acc_d       = acc_q;
        pcm_d       = pcm_q;
        pcm_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (enable_i && !tick) begin
            div_d = div_q + DIV_W'(1);
        end

        if (tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        if (pend_q[c]) begin
                            cur_d[c]  = start_addr_i[c*ADDR_W +: ADDR_W];
                            busy_d[c] = 1'b1;
                        end
                    end
                    pend_d  = trig_i;
                    acc_d   = '0;
                    ch_d    = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StData;
            end
            StData: begin
                acc_d = acc_q + (busy_q[ch_q] ? contrib : '0);
                if (ch_q == LAST_CH) begin
                    state_d = StMix;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = StAddr;
                end
            end
            StMix: begin
                pcm_d       = SAMPLE_W'(sat_val) ^ MID;
                pcm_valid_d = 1'b1;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (busy_q[c]) begin
                        if (cur_q[c] == end_addr_i[c*ADDR_W +: ADDR_W]) begin
                            if (loop_i[c]) begin
                                cur_d[c] = start_addr_i[c*ADDR_W +: ADDR_W];
                            end else begin
                                busy_d[c] = 1'b0;
                                done_d[c] = 1'b1;
                            end
                        end else begin
                            cur_d[c] = cur_q[c] + ADDR_W'(1);
                        end
                    end
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            div_q       <= '0;
            pend_q      <= '0;
            busy_q      <= '0;
            done_q      <= '0;
            cur_q       <= '{default: '0};
            acc_q       <= '0;
            pcm_q       <= MID;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cur_q       <= cur_d;
            acc_q       <= acc_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    audio_dsm #(
        .SAMPLE_W(SAMPLE_W)
    ) u_dsm (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pcm_i  (pcm_q),
        .audio_o(audio_out_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pcm_out_o   = pcm_q;
    assign pcm_valid_o = pcm_valid_q;
    assign overrun_o   = overrun_q;

endmodule
